// File: rtl/enc_pkg.sv
// Shared types and RV32I constants for the instruction encoder.
package enc_pkg;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_LI  = 3'd6,
        FMT_RSV = 3'd7
    } fmt_e;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        fmt_e        fmt;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } enc_req_t;

    typedef struct packed {
        logic [31:0] w0;
        logic [31:0] w1;
        logic        two;
        logic        err;
    } enc_res_t;

    // True when v is a sign extension of its low msb+1 bits.
    function automatic logic fits_s(input logic [31:0] v, input int unsigned msb);
        logic [31:0] m;
        m = 32'hFFFF_FFFF << msb;
        return ((v & m) == m) || ((v & m) == 32'd0);
    endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Request/response bus of the instruction encoder.
interface inst_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_last;
    logic        out_err;

    modport master (
        output in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
               in_rd, in_rs1, in_rs2, in_imm, out_ready,
        input  in_ready, out_valid, out_inst, out_last, out_err
    );

    modport slave (
        input  in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
               in_rd, in_rs1, in_rs2, in_imm, out_ready,
        output in_ready, out_valid, out_inst, out_last, out_err
    );
endinterface

// File: rtl/enc_pack.sv
// Combinational RV32I field packing, range checking and LI expansion.
module enc_pack
    import enc_pkg::*;
(
    input  enc_req_t req,
    output enc_res_t res
);

    logic [19:0] hi;

    always_comb begin
        res     = '0;
        res.w0  = NOP;
        res.w1  = NOP;
        // (imm + 0x800) >> 12 without a 32-bit adder: the carry into bit 12 is imm[11]
        hi      = req.imm[31:12] + {19'd0, req.imm[11]};
        case (req.fmt)
            FMT_R: res.w0 = {req.funct7, req.rs2, req.rs1, req.funct3, req.rd, req.opcode};
            FMT_I: begin
                if (fits_s(req.imm, 11))
                    res.w0 = {req.imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
                else
                    res.err = 1'b1;
            end
            FMT_S: begin
                if (fits_s(req.imm, 11))
                    res.w0 = {req.imm[11:5], req.rs2, req.rs1, req.funct3, req.imm[4:0], req.opcode};
                else
                    res.err = 1'b1;
            end
            FMT_B: begin
                if (fits_s(req.imm, 12) && !req.imm[0])
                    res.w0 = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, req.funct3,
                              req.imm[4:1], req.imm[11], req.opcode};
                else
                    res.err = 1'b1;
            end
            FMT_U: begin
                if (req.imm[11:0] == 12'd0)
                    res.w0 = {req.imm[31:12], req.rd, req.opcode};
                else
                    res.err = 1'b1;
            end
            FMT_J: begin
                if (fits_s(req.imm, 20) && !req.imm[0])
                    res.w0 = {req.imm[20], req.imm[10:1], req.imm[11], req.imm[19:12],
                              req.rd, req.opcode};
                else
                    res.err = 1'b1;
            end
            FMT_LI: begin
                if (fits_s(req.imm, 11)) begin
                    res.w0 = {req.imm[11:0], 5'd0, 3'b000, req.rd, OP_IMM};
                end else begin
                    res.w0  = {hi, req.rd, LUI};
                    res.w1  = {req.imm[11:0], req.rd, 3'b000, req.rd, OP_IMM};
                    res.two = |req.imm[11:0];
                end
            end
            default: res.err = 1'b1;
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// RV32I instruction encoder: accepts one request, emits one or two words.
module inst_encoder
    import enc_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    inst_encoder_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, EMIT1, EMIT2} state_e;

    state_e      state;
    enc_req_t    req;
    enc_res_t    res;
    logic [31:0] pend;
    logic [31:0] inst;
    logic        rdy, vld, last, err;
    logic        accept, take;

    assign req = '{fmt:    fmt_e'(bus.in_fmt),
                   opcode: bus.in_opcode,
                   funct3: bus.in_funct3,
                   funct7: bus.in_funct7,
                   rd:     bus.in_rd,
                   rs1:    bus.in_rs1,
                   rs2:    bus.in_rs2,
                   imm:    bus.in_imm};

    enc_pack u_pack (.req(req), .res(res));

    assign accept        = bus.in_valid && rdy;
    assign take          = vld && bus.out_ready;
    assign bus.in_ready  = rdy;
    assign bus.out_valid = vld;
    assign bus.out_inst  = inst;
    assign bus.out_last  = last;
    assign bus.out_err   = err;

    // The request is captured already encoded: word 0 goes straight to the
    // output register, word 1 waits in pend until word 0 is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rdy   <= 1'b0;
            vld   <= 1'b0;
            inst  <= '0;
            last  <= 1'b0;
            err   <= 1'b0;
            pend  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= EMIT1;
                        rdy   <= 1'b0;
                        vld   <= 1'b1;
                        inst  <= res.w0;
                        last  <= !res.two;
                        err   <= res.err;
                        pend  <= res.w1;
                    end else begin
                        rdy   <= 1'b1;
                    end
                end
                EMIT1: begin
                    if (take && !last) begin
                        state <= EMIT2;
                        inst  <= pend;
                        last  <= 1'b1;
                    end else if (take) begin
                        state <= IDLE;
                        rdy   <= 1'b1;
                        vld   <= 1'b0;
                        inst  <= '0;
                        last  <= 1'b0;
                        err   <= 1'b0;
                    end
                end
                EMIT2: begin
                    if (take) begin
                        state <= IDLE;
                        rdy   <= 1'b1;
                        vld   <= 1'b0;
                        inst  <= '0;
                        last  <= 1'b0;
                        err   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    vld   <= 1'b0;
                end
            endcase
        end
    end

endmodule
